// File: rtl/sat_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with per-beat add/sub, saturate/wrap
// and signed/unsigned modes. Define SAT_ADDSUB_FLAGS_EN to add the N/Z/V flag outputs.
module sat_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  input  logic             uns,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SAT_ADDSUB_FLAGS_EN
  ,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
`endif
);

  localparam int NG = WIDTH / 4;

  // Groups per stage; the remainder goes to the latest stages.
  function automatic int grp_cnt(input int k);
    return (NG / STAGES) + ((k >= (STAGES - (NG % STAGES))) ? 1 : 0);
  endfunction

  function automatic int grp_lo(input int k);
    int lo;
    lo = 0;
    for (int j = 0; j < k; j++) begin
      lo = lo + grp_cnt(j);
    end
    return lo;
  endfunction

  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Index STAGES-1 is the output register: its sum holds the selected result.
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             c_q     [STAGES];
  logic             c_d     [STAGES];
  logic             sub_q   [STAGES];
  logic             sub_d   [STAGES];
  logic             sat_q   [STAGES];
  logic             sat_d   [STAGES];
  logic             uns_q   [STAGES];
  logic             uns_d   [STAGES];
`ifdef SAT_ADDSUB_FLAGS_EN
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_v_q, flag_v_d;
`endif

  logic advance_s;

  assign advance_s = !valid_q[STAGES-1] | out_ready;
  assign in_ready  = advance_s;
  assign out_valid = valid_q[STAGES-1];
  assign result    = sum_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
`ifdef SAT_ADDSUB_FLAGS_EN
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;
  assign flag_v    = flag_v_q;
`endif

  // Per-stage group arithmetic, plus overflow detection and selection in the last stage.
  always_comb begin
    logic [WIDTH-1:0] sa_s, sb_s, sum_s, sel_s;
    logic             sv_s, sc_s, ssub_s, ssat_s, suns_s, c_s, rng_s;
    logic             pos_s, neg_s, ovf_s;
    logic [4:0]       cla_s;
    int               lo, hi;
    sa_s = '0; sb_s = '0; sum_s = '0; sel_s = '0;
    sv_s = 1'b0; sc_s = 1'b0; ssub_s = 1'b0; ssat_s = 1'b0; suns_s = 1'b0;
    c_s = 1'b0; rng_s = 1'b0; pos_s = 1'b0; neg_s = 1'b0; ovf_s = 1'b0;
    cla_s = 5'b0_0000;
    lo = 0;
    hi = 0;
`ifdef SAT_ADDSUB_FLAGS_EN
    flag_n_d = 1'b0;
    flag_z_d = 1'b0;
    flag_v_d = 1'b0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        sv_s   = in_valid;
        sa_s   = a;
        sb_s   = sub ? ~b : b;
        sum_s  = '0;
        sc_s   = sub;
        ssub_s = sub;
        ssat_s = sat;
        suns_s = uns;
      end else begin
        sv_s   = valid_q[k-1];
        sa_s   = a_q[k-1];
        sb_s   = b_q[k-1];
        sum_s  = sum_q[k-1];
        sc_s   = c_q[k-1];
        ssub_s = sub_q[k-1];
        ssat_s = sat_q[k-1];
        suns_s = uns_q[k-1];
      end
      lo  = grp_lo(k);
      hi  = lo + grp_cnt(k);
      c_s = sc_s;
      for (int g = 0; g < NG; g++) begin
        rng_s          = (g >= lo) && (g < hi);
        cla_s          = cla4(sa_s[4*g +: 4], sb_s[4*g +: 4], c_s);
        sum_s[4*g +: 4] = rng_s ? cla_s[3:0] : sum_s[4*g +: 4];
        c_s            = rng_s ? cla_s[4] : c_s;
      end
      // B was already inverted for subtraction, so its MSB is the effective sign.
      pos_s = !sa_s[WIDTH-1] & !sb_s[WIDTH-1] &  sum_s[WIDTH-1];
      neg_s =  sa_s[WIDTH-1] &  sb_s[WIDTH-1] & !sum_s[WIDTH-1];
      ovf_s = suns_s ? (ssub_s ? !c_s : c_s) : (pos_s | neg_s);
      if (ssat_s && ovf_s) begin
        if (suns_s) begin
          sel_s = ssub_s ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end else begin
          sel_s = pos_s ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
      end else begin
        sel_s = sum_s;
      end
      valid_d[k] = sv_s;
      a_d[k]     = sa_s;
      b_d[k]     = sb_s;
      c_d[k]     = c_s;
      sub_d[k]   = ssub_s;
      sat_d[k]   = ssat_s;
      uns_d[k]   = suns_s;
      if (k == STAGES - 1) begin
        sum_d[k] = sel_s;
`ifdef SAT_ADDSUB_FLAGS_EN
        flag_n_d = sel_s[WIDTH-1];
        flag_z_d = (sel_s == {WIDTH{1'b0}});
        flag_v_d = ovf_s;
`endif
      end else begin
        sum_d[k] = sum_s;
      end
    end
  end

  // Whole pipe shifts together on advance and freezes otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        c_q[k]     <= 1'b0;
        sub_q[k]   <= 1'b0;
        sat_q[k]   <= 1'b0;
        uns_q[k]   <= 1'b0;
      end
`ifdef SAT_ADDSUB_FLAGS_EN
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
`endif
    end else if (advance_s) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        c_q[k]     <= c_d[k];
        sub_q[k]   <= sub_d[k];
        sat_q[k]   <= sat_d[k];
        uns_q[k]   <= uns_d[k];
      end
`ifdef SAT_ADDSUB_FLAGS_EN
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
`endif
    end
  end

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Bench for sat_addsub_pipe: directed W16/S2 instance plus random W32 instances
// at STAGES 1, 3 and 8, all checked against an arithmetic reference model.
module tb_sat_addsub_pipe;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  logic        d_valid, d_sub, d_sat, d_uns, d_oready;
  logic [15:0] d_a, d_b;

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        v;
    int          acc;
    int          stl;
  } exp_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int cfg, input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL cfg%0d %s: got %0h, expected %0h", cfg, name, act, exp);
    end
  endtask

  // Exact-integer reference: returns {overflow, carry_out, result}.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic sub, input logic sat, input logic uns);
    longint mask, ua, ub, ext, sa, sb, ex, ue, maxv, minv, satv;
    logic [63:0] raw;
    logic c, v;
    mask = (64'sd1 <<< w) - 64'sd1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    ext  = sub ? ua + (~ub & mask) + 64'sd1 : ua + ub;
    c    = ext[w];
    raw  = 64'(ext & mask);
    sa   = ua[w-1] ? ua - (64'sd1 <<< w) : ua;
    sb   = ub[w-1] ? ub - (64'sd1 <<< w) : ub;
    maxv = (64'sd1 <<< (w - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (w - 1));
    if (uns) begin
      ue   = sub ? ua - ub : ua + ub;
      v    = (ue > mask) || (ue < 64'sd0);
      satv = (ue < 64'sd0) ? 64'sd0 : mask;
    end else begin
      ex   = sub ? sa - sb : sa + sb;
      v    = (ex > maxv) || (ex < minv);
      satv = (ex > maxv) ? maxv : (minv & mask);
    end
    return {v, c, (sat && v) ? 64'(satv) : raw};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int W = (gi == 0) ? 16 : 32;
    localparam int S = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 3 : 8;
    logic         in_valid, in_ready, sub, sat, uns, out_valid, out_ready, cout;
    logic [W-1:0] a, b, result;
`ifdef SAT_ADDSUB_FLAGS_EN
    logic         flag_n, flag_z, flag_v;
`endif
    exp_t         q[$];
    exp_t         e;
    logic [65:0]  m;
    int           cyc = 0;
    int           stalls = 0;
    int           pending = 0;

    sat_addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .sat(sat), .uns(uns),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout)
`ifdef SAT_ADDSUB_FLAGS_EN
      , .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
`endif
    );

    if (gi == 0) begin : g_dir
      assign in_valid  = d_valid;
      assign a         = d_a;
      assign b         = d_b;
      assign sub       = d_sub;
      assign sat       = d_sat;
      assign uns       = d_uns;
      assign out_ready = d_oready;
    end else begin : g_rnd
      initial begin
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; sat = 1'b0; uns = 1'b0;
        @(negedge rst);
        for (int n = 0; n < 400; n++) begin
          @(posedge clk); #1;
          in_valid  = ($urandom_range(0, 3) != 0);
          out_ready = ($urandom_range(0, 3) != 0);
          a = pick(); b = pick();
          sub = 1'($urandom_range(0, 1));
          sat = 1'($urandom_range(0, 1));
          uns = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
      end
    end

    // Scoreboard: every cycle with out_valid is compared with the oldest accepted beat.
    always @(negedge clk) begin
      cyc++;
      if (rst) begin
        q.delete();
      end else begin
        check(gi, "in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid) begin
          if (q.size() == 0) begin
            check(gi, "spurious_out_valid", 64'(out_valid), 64'd0);
          end else begin
            e = q[0];
            check(gi, "result", 64'(result), e.res);
            check(gi, "cout", 64'(cout), 64'(e.c));
`ifdef SAT_ADDSUB_FLAGS_EN
            check(gi, "flag_v", 64'(flag_v), 64'(e.v));
            check(gi, "flag_n", 64'(flag_n), 64'(e.res[W-1]));
            check(gi, "flag_z", 64'(flag_z), 64'(e.res[W-1:0] == '0));
`endif
            if (out_ready) begin
              check(gi, "latency", 64'(cyc - e.acc), 64'(S + stalls - e.stl));
              void'(q.pop_front());
            end
          end
        end
        if (in_valid && in_ready) begin
          m = model(W, 64'(a), 64'(b), sub, sat, uns);
          q.push_back('{res: m[63:0], c: m[64], v: m[65], acc: cyc, stl: stalls});
        end
        if (out_valid && !out_ready) stalls++;
      end
      pending = q.size();
    end
  end

  task automatic send(input logic [15:0] va, input logic [15:0] vb,
                      input logic vsub, input logic vsat, input logic vuns);
    logic acc;
    d_valid = 1'b1; d_a = va; d_b = vb; d_sub = vsub; d_sat = vsat; d_uns = vuns;
    acc = 1'b0;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      acc = g_cfg[0].in_ready;
    end
    check(0, "accept", 64'(acc), 64'd1);
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  // Pins the model to a hand-computed answer, then streams the beat to the DUT.
  task automatic vec(input logic [15:0] va, input logic [15:0] vb, input logic vsub,
                     input logic vsat, input logic vuns, input logic [15:0] er,
                     input logic ec, input logic ev);
    logic [65:0] mm;
    mm = model(16, 64'(va), 64'(vb), vsub, vsat, vuns);
    check(0, "model_res", mm[63:0], 64'(er));
    check(0, "model_cout", 64'(mm[64]), 64'(ec));
    check(0, "model_v", 64'(mm[65]), 64'(ev));
    send(va, vb, vsub, vsat, vuns);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && g_cfg[0].pending != 0; t++) @(negedge clk);
    check(0, "drain", 64'(g_cfg[0].pending), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int s0;
    nvec = 0; nerr = 0;
    rst = 1'b1;
    d_valid = 1'b0; d_oready = 1'b1;
    d_a = 16'h0000; d_b = 16'h0000; d_sub = 1'b0; d_sat = 1'b0; d_uns = 1'b0;
    repeat (2) @(posedge clk); #1;
    check(0, "reset_out_valid", 64'(g_cfg[0].out_valid), 64'd0);
    check(0, "reset_result", 64'(g_cfg[0].result), 64'd0);
    check(0, "reset_cout", 64'(g_cfg[0].cout), 64'd0);
`ifdef SAT_ADDSUB_FLAGS_EN
    check(0, "reset_flags", 64'({g_cfg[0].flag_n, g_cfg[0].flag_z, g_cfg[0].flag_v}), 64'd0);
`endif
    rst = 1'b0;

    vec(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    drain();
    vec(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);
    vec(16'h0003, 16'hFFFE, 1'b1, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0);
    vec(16'hFFF0, 16'h0020, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    vec(16'h0005, 16'h0009, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1);
    vec(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    drain();

    s0 = g_cfg[0].stalls;
    fork
      begin
        send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0);
        send(16'h0001, 16'h0002, 1'b1, 1'b1, 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send(16'h7000, 16'h9000, 1'b1, 1'b1, 1'b0);
        send(16'h00FF, 16'h0F0F, 1'b1, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk); #1 d_oready = 1'b0;
        repeat (3) @(posedge clk); #1 d_oready = 1'b1;
      end
    join
    drain();
    check(0, "stall_cycles", 64'(g_cfg[0].stalls - s0), 64'd3);

    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check(0, "async_rst_out_valid", 64'(g_cfg[0].out_valid), 64'd0);
    check(0, "async_rst_result", 64'(g_cfg[0].result), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    vec(16'h0003, 16'hFFFE, 1'b1, 1'b1, 1'b0, 16'h0005, 1'b0, 1'b0);
    drain();

    repeat (450) @(posedge clk);
    @(negedge clk);
    check(1, "drain", 64'(g_cfg[1].pending), 64'd0);
    check(2, "drain", 64'(g_cfg[2].pending), 64'd0);
    check(3, "drain", 64'(g_cfg[3].pending), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
